// File: rtl/miner_work_pkg.sv
// Register map, control bits, status layout and FSM states for the miner work loader.
package miner_work_pkg;

  // Register offsets from the window base address
  localparam logic [31:0] OFF_WORD0 = 32'h0000_0004;
  localparam logic [31:0] OFF_NONCE = 32'h0000_0054;
  localparam logic [31:0] OFF_CTRL  = 32'h0000_0058;

  // CTRL write data bit positions
  localparam int unsigned CTRL_COMMIT = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_CLRERR = 2;

  // Status word field positions
  localparam int unsigned STAT_BITMAP_LSB = 0;
  localparam int unsigned STAT_PENDING    = 20;
  localparam int unsigned STAT_ERR_INC    = 21;
  localparam int unsigned STAT_ERR_OVR    = 22;
  localparam int unsigned STAT_SEQ_LSB    = 24;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // Byte-lane merge of a 32-bit register write
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/miner_work_loader.sv
// Assembles a shadow block header + nonce from register writes and offers it to the miner on COMMIT.
module miner_work_loader
  import miner_work_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0500,
  parameter int unsigned NUM_WORDS = 20,
  parameter int unsigned SEQ_W     = 8
) (
  input  logic                   clk_main_a0,
  input  logic                   rst_main_n,
  input  logic                   i_wr_valid,
  input  logic [31:0]            i_wr_addr,
  input  logic [31:0]            i_wr_data,
  input  logic [3:0]             i_wr_strb,
  output logic                   o_work_valid,
  input  logic                   i_work_ready,
  output logic [NUM_WORDS*32-1:0] o_work_block,
  output logic [31:0]            o_work_nonce_start,
  output logic [31:0]            o_status
);

  localparam int unsigned BLK_W   = NUM_WORDS * 32;
  localparam int unsigned IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [31:0] WIN_END = OFF_WORD0 + 32'(4 * NUM_WORDS);

  logic [31:0]          r_shadow [NUM_WORDS];
  logic [31:0]          r_nonce;
  logic [BLK_W-1:0]     r_active;
  logic [31:0]          r_active_nonce;
  logic [NUM_WORDS-1:0] r_bitmap;
  logic [SEQ_W-1:0]     r_seq;
  logic                 r_err_inc;
  logic                 r_err_ovr;
  logic                 r_work_valid;
  logic [31:0]          r_status;
  state_e               r_state;

  logic [31:0]          w_off;
  logic [31:0]          w_word_rel;
  logic [IDX_W-1:0]     w_word_idx;
  logic                 w_word_hit;
  logic                 w_nonce_hit;
  logic                 w_ctrl_hit;
  logic                 w_commit;
  logic                 w_abort;
  logic                 w_clrerr;
  logic                 w_full;
  logic                 w_hs;
  logic                 w_accept;
  logic                 w_rej_ovr;
  logic                 w_rej_inc;
  state_e               w_state_nxt;
  logic [31:0]          w_status;

  // Address decode of the incoming write beat
  always_comb begin
    w_off       = i_wr_addr - BASE_ADDR;
    w_word_rel  = w_off - OFF_WORD0;
    w_word_idx  = IDX_W'(w_word_rel >> 2);
    w_word_hit  = i_wr_valid && (w_off[1:0] == 2'b00) && (w_off >= OFF_WORD0) && (w_off < WIN_END);
    w_nonce_hit = i_wr_valid && (w_off == OFF_NONCE);
    w_ctrl_hit  = i_wr_valid && (w_off == OFF_CTRL);
    w_clrerr    = w_ctrl_hit && i_wr_data[CTRL_CLRERR];
    w_abort     = w_ctrl_hit && i_wr_data[CTRL_ABORT];
    w_commit    = w_ctrl_hit && i_wr_data[CTRL_COMMIT];
  end

  // FSM next state and commit accept/reject decisions; ABORT in the same write empties the bitmap first
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rej_ovr   = 1'b0;
    w_rej_inc   = 1'b0;
    w_hs        = r_work_valid && i_work_ready;
    w_full      = (&r_bitmap) && !w_abort;
    if (w_commit && !w_full) w_rej_inc = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_commit && w_full) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_commit && w_full) begin
          if (w_hs) w_accept  = 1'b1;
          else      w_rej_ovr = 1'b1;
        end else if (w_hs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and offered-work flag
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_state      <= ST_IDLE;
      r_work_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_work_valid <= (w_state_nxt == ST_PENDING);
    end
  end

  // Shadow header words and nonce, byte-enabled writes in any state
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_shadow[i] <= '0;
      r_nonce <= '0;
    end else begin
      if (w_word_hit)  r_shadow[w_word_idx] <= merge_bytes(r_shadow[w_word_idx], i_wr_data, i_wr_strb);
      if (w_nonce_hit) r_nonce <= merge_bytes(r_nonce, i_wr_data, i_wr_strb);
    end
  end

  // Active slot, loaded only on an accepted commit; word 0 sits in the top 32 bits
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_active       <= '0;
      r_active_nonce <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_active[BLK_W-1-32*i -: 32] <= r_shadow[i];
      r_active_nonce <= r_nonce;
    end
  end

  // Word coverage bitmap, sequence counter and sticky errors
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_bitmap  <= '0;
      r_seq     <= '0;
      r_err_inc <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      if (w_accept || w_abort)                    r_bitmap <= '0;
      else if (w_word_hit && i_wr_strb == 4'hF)   r_bitmap[w_word_idx] <= 1'b1;
      if (w_accept) r_seq <= r_seq + SEQ_W'(1);
      r_err_inc <= (r_err_inc && !w_clrerr) || w_rej_inc;
      r_err_ovr <= (r_err_ovr && !w_clrerr) || w_rej_ovr;
    end
  end

  // Status word assembled from current state, registered for BAR0 reads
  always_comb begin
    w_status                                = '0;
    w_status[STAT_BITMAP_LSB +: NUM_WORDS]  = r_bitmap;
    w_status[STAT_PENDING]                  = r_work_valid;
    w_status[STAT_ERR_INC]                  = r_err_inc;
    w_status[STAT_ERR_OVR]                  = r_err_ovr;
    w_status[STAT_SEQ_LSB +: SEQ_W]         = r_seq;
  end

  // Status register
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) r_status <= '0;
    else             r_status <= w_status;
  end

  assign o_work_valid       = r_work_valid;
  assign o_work_block       = r_active;
  assign o_work_nonce_start = r_active_nonce;
  assign o_status           = r_status;

endmodule

// File: tb/tb_miner_work_loader.sv
// Randomized self-checking bench for miner_work_loader against a register-level behavioural model.
module tb_miner_work_loader;

  localparam logic [31:0] BASE = 32'h0000_0500;
  localparam logic [31:0] A_NONCE = BASE + 32'h54;
  localparam logic [31:0] A_CTRL  = BASE + 32'h58;

  logic         clk_main_a0 = 1'b0;
  logic         rst_main_n  = 1'b0;
  logic         i_wr_valid  = 1'b0;
  logic [31:0]  i_wr_addr   = '0;
  logic [31:0]  i_wr_data   = '0;
  logic [3:0]   i_wr_strb   = '0;
  logic         i_work_ready = 1'b0;
  logic         o_work_valid;
  logic [639:0] o_work_block;
  logic [31:0]  o_work_nonce_start;
  logic [31:0]  o_status;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_shadow [20];
  logic [31:0] m_act    [20];
  bit          m_have   [20];
  logic [31:0] m_nonce, m_act_nonce, m_status;
  logic [7:0]  m_seq;
  bit          m_valid, m_inc, m_ovr;

  miner_work_loader dut (
    .clk_main_a0        (clk_main_a0),
    .rst_main_n         (rst_main_n),
    .i_wr_valid         (i_wr_valid),
    .i_wr_addr          (i_wr_addr),
    .i_wr_data          (i_wr_data),
    .i_wr_strb          (i_wr_strb),
    .o_work_valid       (o_work_valid),
    .i_work_ready       (i_work_ready),
    .o_work_block       (o_work_block),
    .o_work_nonce_start (o_work_nonce_start),
    .o_status           (o_status)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] pack_status();
    logic [31:0] s;
    s = {m_seq, 1'b0, m_ovr, m_inc, m_valid, 20'h0};
    for (int i = 0; i < 20; i++) s[i] = m_have[i];
    return s;
  endfunction

  function automatic logic [639:0] exp_block();
    logic [639:0] b;
    for (int i = 0; i < 20; i++) b[639-32*i -: 32] = m_act[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 20; i++) begin m_shadow[i] = '0; m_act[i] = '0; m_have[i] = 0; end
    m_nonce = '0; m_act_nonce = '0; m_status = '0; m_seq = '0;
    m_valid = 0; m_inc = 0; m_ovr = 0;
  endtask

  // One clock of the register-level rules, applied to the inputs presented this cycle
  task automatic model_step();
    logic [31:0] off, nxt_status;
    bit hs, all, accept;
    int idx;
    nxt_status = pack_status();
    hs = m_valid && i_work_ready;
    accept = 0;
    if (i_wr_valid) begin
      off = i_wr_addr - BASE;
      if (off >= 32'h4 && off < 32'h54 && off[1:0] == 2'b00) begin
        idx = int'((off - 32'h4) / 4);
        m_shadow[idx] = bmerge(m_shadow[idx], i_wr_data, i_wr_strb);
        if (i_wr_strb == 4'hF) m_have[idx] = 1;
      end else if (off == 32'h54) begin
        m_nonce = bmerge(m_nonce, i_wr_data, i_wr_strb);
      end else if (off == 32'h58) begin
        if (i_wr_data[2]) begin m_inc = 0; m_ovr = 0; end
        if (i_wr_data[1]) for (int i = 0; i < 20; i++) m_have[i] = 0;
        if (i_wr_data[0]) begin
          all = 1;
          for (int i = 0; i < 20; i++) if (!m_have[i]) all = 0;
          if (!all)                m_inc = 1;
          else if (!m_valid || hs) accept = 1;
          else                     m_ovr = 1;
        end
      end
    end
    if (accept) begin
      for (int i = 0; i < 20; i++) begin m_act[i] = m_shadow[i]; m_have[i] = 0; end
      m_act_nonce = m_nonce;
      m_seq = m_seq + 8'd1;
      m_valid = 1;
    end else if (hs) begin
      m_valid = 0;
    end
    m_status = nxt_status;
  endtask

  task automatic step();
    model_step();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d; i_wr_strb = s;
    step();
    i_wr_valid = 1'b0;
  endtask

  task automatic idle();
    i_wr_valid = 1'b0;
    step();
  endtask

  task automatic fill(input int skip);
    for (int i = 0; i < 20; i++) if (i != skip) wr(BASE + 32'h4 + 32'(4*i), $urandom, 4'hF);
  endtask

  task automatic test_reset();
    model_reset();
    rst_main_n = 1'b0;
    repeat (3) @(posedge clk_main_a0);
    #1 rst_main_n = 1'b1;
    checks++; if (o_work_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_work_valid); end
    checks++; if (o_status !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", o_status); end
    checks++; if (o_work_block !== 640'h0) begin errors++; $display("FAIL reset_block got %h want 0", o_work_block); end
    checks++; if (o_work_nonce_start !== 32'h0) begin errors++; $display("FAIL reset_nonce got %h want 0", o_work_nonce_start); end
  endtask

  task automatic test_commit();
    i_work_ready = 1'b0;
    for (int i = 0; i < 20; i++) wr(BASE + 32'h4 + 32'(4*i), 32'(i + 1), 4'hF);
    wr(A_NONCE, 32'h100, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    checks++; if (o_work_valid !== 1'b1) begin errors++; $display("FAIL commit_valid got %0b want 1", o_work_valid); end
    checks++; if (o_work_block[639:608] !== 32'h1) begin errors++; $display("FAIL commit_word0 got %h want 1", o_work_block[639:608]); end
    checks++; if (o_work_block[31:0] !== 32'h14) begin errors++; $display("FAIL commit_word19 got %h want 14", o_work_block[31:0]); end
    checks++; if (o_work_nonce_start !== 32'h100) begin errors++; $display("FAIL commit_nonce got %h want 100", o_work_nonce_start); end
    idle();
    checks++; if (o_status !== 32'h0110_0000) begin errors++; $display("FAIL commit_status got %h want 01100000", o_status); end
    i_work_ready = 1'b1;
    idle();
    i_work_ready = 1'b0;
    checks++; if (o_work_valid !== 1'b0) begin errors++; $display("FAIL commit_handshake_valid got %0b want 0", o_work_valid); end
  endtask

  task automatic test_incomplete();
    fill(19);
    wr(A_CTRL, 32'h1, 4'hF);
    checks++; if (o_work_valid !== 1'b0) begin errors++; $display("FAIL inc_valid got %0b want 0", o_work_valid); end
    idle();
    checks++; if (o_status[21] !== 1'b1) begin errors++; $display("FAIL inc_err got %0b want 1", o_status[21]); end
    checks++; if (o_status !== m_status) begin errors++; $display("FAIL inc_status got %h want %h", o_status, m_status); end
    wr(A_CTRL, 32'h4, 4'hF);
    idle();
    checks++; if (o_status[21] !== 1'b0) begin errors++; $display("FAIL inc_clrerr got %0b want 0", o_status[21]); end
  endtask

  task automatic test_overflow();
    logic [639:0] blk_a;
    i_work_ready = 1'b0;
    fill(-1);
    wr(A_CTRL, 32'h1, 4'hF);
    blk_a = exp_block();
    fill(-1);
    wr(A_CTRL, 32'h1, 4'hF);
    idle();
    checks++; if (o_status[22] !== 1'b1) begin errors++; $display("FAIL ovr_err got %0b want 1", o_status[22]); end
    checks++; if (o_work_block !== blk_a) begin errors++; $display("FAIL ovr_block got %h want %h", o_work_block, blk_a); end
    checks++; if (o_status !== m_status) begin errors++; $display("FAIL ovr_status got %h want %h", o_status, m_status); end
    i_work_ready = 1'b1;
    idle();
    i_work_ready = 1'b0;
    checks++; if (o_work_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop got %0b want 0", o_work_valid); end
    wr(A_CTRL, 32'h6, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_a;
    i_work_ready = 1'b0;
    fill(-1);
    wr(A_CTRL, 32'h1, 4'hF);
    seq_a = m_seq;
    for (int i = 0; i < 20; i++) begin
      wr(BASE + 32'h4 + 32'(4*i), $urandom, 4'hF);
      checks++; if (o_work_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold got %0b want 1", o_work_valid); end
    end
    i_work_ready = 1'b1;
    wr(A_CTRL, 32'h1, 4'hF);
    i_work_ready = 1'b0;
    checks++; if (o_work_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0b want 1", o_work_valid); end
    checks++; if (o_work_block !== exp_block()) begin errors++; $display("FAIL b2b_block got %h want %h", o_work_block, exp_block()); end
    idle();
    checks++; if (o_status[31:24] !== seq_a + 8'd1) begin errors++; $display("FAIL b2b_seq got %h want %h", o_status[31:24], seq_a + 8'd1); end
    i_work_ready = 1'b1;
    idle();
    i_work_ready = 1'b0;
    checks++; if (o_work_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", o_work_valid); end
  endtask

  task automatic test_partial();
    logic [31:0] st;
    wr(A_CTRL, 32'h2, 4'hF);
    wr(BASE + 32'h4, 32'hAAAA_BBBB, 4'b0011);
    idle();
    checks++; if (o_status[0] !== 1'b0) begin errors++; $display("FAIL part_bitmap got %0b want 0", o_status[0]); end
    idle();
    st = o_status;
    wr(BASE + 32'hFC, 32'h1, 4'hF);
    idle(); idle();
    checks++; if (o_status !== st) begin errors++; $display("FAIL part_ignored got %h want %h", o_status, st); end
    wr(BASE + 32'h4, 32'h1234_5678, 4'hF);
    wr(BASE + 32'h4, 32'hAAAA_BBBB, 4'b0011);
    fill(0);
    wr(A_CTRL, 32'h1, 4'hF);
    checks++; if (o_work_block[639:608] !== 32'h1234_BBBB) begin errors++; $display("FAIL part_merge got %h want 1234bbbb", o_work_block[639:608]); end
    i_work_ready = 1'b1;
    idle();
    i_work_ready = 1'b0;
  endtask

  task automatic test_random();
    int op;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 26; i++) begin
        i_work_ready = 1'($urandom_range(0, 1));
        op = $urandom_range(0, 19);
        i_wr_valid = 1'b1;
        i_wr_data  = $urandom;
        i_wr_strb  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
        if (i < 20)       i_wr_addr = BASE + 32'h4 + 32'(4*i);
        else if (op < 3)  i_wr_addr = A_NONCE;
        else if (op < 5)  i_wr_addr = BASE + 32'($urandom_range(0, 255));
        else if (op < 7)  i_wr_valid = 1'b0;
        else begin
          i_wr_addr = A_CTRL;
          i_wr_data = {29'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
        end
        step();
        i_wr_valid = 1'b0;
        checks++; if (o_work_valid !== m_valid) begin errors++; $display("FAIL rnd_valid got %0b want %0b", o_work_valid, m_valid); end
        checks++; if (o_work_block !== exp_block()) begin errors++; $display("FAIL rnd_block got %h want %h", o_work_block, exp_block()); end
        checks++; if (o_work_nonce_start !== m_act_nonce) begin errors++; $display("FAIL rnd_nonce got %h want %h", o_work_nonce_start, m_act_nonce); end
        checks++; if (o_status !== m_status) begin errors++; $display("FAIL rnd_status got %h want %h", o_status, m_status); end
      end
    end
    i_work_ready = 1'b0;
  endtask

  task automatic test_reset_pending_and_wrap();
    i_work_ready = 1'b0;
    fill(-1);
    wr(A_CTRL, 32'h1, 4'hF);
    idle();
    checks++; if (o_work_valid !== 1'b1) begin errors++; $display("FAIL rstp_pre got %0b want 1", o_work_valid); end
    #2 rst_main_n = 1'b0;
    #1;
    checks++; if (o_work_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid got %0b want 0", o_work_valid); end
    checks++; if (o_status !== 32'h0) begin errors++; $display("FAIL rstp_status got %h want 0", o_status); end
    model_reset();
    @(posedge clk_main_a0);
    #1 rst_main_n = 1'b1;
    i_work_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      fill(-1);
      wr(A_CTRL, 32'h1, 4'hF);
      if (k == 254) begin
        idle(); idle();
        checks++; if (o_status[31:24] !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %h want ff", o_status[31:24]); end
      end
    end
    idle(); idle();
    checks++; if (o_status[31:24] !== 8'h00) begin errors++; $display("FAIL wrap_zero got %h want 00", o_status[31:24]); end
    checks++; if (o_status !== m_status) begin errors++; $display("FAIL wrap_status got %h want %h", o_status, m_status); end
    i_work_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_incomplete();
    test_overflow();
    test_back_to_back();
    test_partial();
    test_random();
    test_reset_pending_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
